// File: rtl/gate_delay_meter.sv
// Measures how many clock edges the observed output of the (a&b)|c gate stage lags each expected transition.
// Optional macro GATE_DELAY_METER_MINMAX_EN builds the min/max delay trackers; otherwise those ports are constant.
module gate_delay_meter #(
  parameter int CW       = 8,
  parameter int MAX_WAIT = 32,
  parameter int NW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a,
  input  logic          b,
  input  logic          c,
  input  logic          gate_out,
  input  logic          clr,
  output logic          meas_valid,
  output logic [CW-1:0] meas_delay,
  output logic          meas_rise,
  output logic [CW-1:0] min_delay,
  output logic [CW-1:0] max_delay,
  output logic [NW-1:0] meas_cnt,
  output logic [NW-1:0] abort_cnt,
  output logic          timeout,
  output logic          err
);

  typedef enum logic [1:0] {PRIME, IDLE, WAIT, TMO} state_t;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);
  localparam logic [CW-1:0] CW_ONES = {CW{1'b1}};
  localparam logic [NW-1:0] NW_ONES = {NW{1'b1}};

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          exp_q_reg;
  logic          exp_now;
  logic          chg;
  logic          match;
  logic          done;
  logic [CW-1:0] done_delay;
  logic          abort_inc;
  logic          tmo_hit;

  // exp_q is meaningless until PRIME has loaded it, so no change is seen there.
  always_comb begin
    exp_now = (a & b) | c;
    chg     = (state_reg != PRIME) && (exp_now != exp_q_reg);
    match   = (gate_out == exp_now);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= PRIME;
      cnt_reg   <= '0;
      exp_q_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      exp_q_reg <= exp_now;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done       = 1'b0;
    done_delay = '0;
    abort_inc  = 1'b0;
    tmo_hit    = 1'b0;
    case (state_reg)
      PRIME: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      IDLE: begin
        if (chg) begin
          if (match) begin
            done = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = CW'(1);
          end
        end
      end
      WAIT: begin
        if (chg) begin
          abort_inc = 1'b1;
          if (match) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = CW'(1);
          end
        end else if (match) begin
          done       = 1'b1;
          done_delay = cnt_reg;
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == MAX_CNT) begin
          tmo_hit    = 1'b1;
          state_next = TMO;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      TMO: begin
        // A late arrival of the abandoned transition resynchronises silently.
        if (match) begin
          state_next = IDLE;
        end else if (chg) begin
          abort_inc  = 1'b1;
          state_next = WAIT;
          cnt_next   = CW'(1);
        end
      end
      default: begin
        state_next = PRIME;
        cnt_next   = '0;
      end
    endcase
  end

  // Per-measurement result; updates even while clr is asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      meas_valid <= 1'b0;
      meas_delay <= '0;
      meas_rise  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= done;
      timeout    <= tmo_hit;
      if (done) begin
        meas_delay <= done_delay;
        meas_rise  <= exp_now;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      meas_cnt  <= '0;
      abort_cnt <= '0;
      err       <= 1'b0;
    end else begin
      if (done && (meas_cnt != NW_ONES)) begin
        meas_cnt <= meas_cnt + NW'(1);
      end
      if (abort_inc && (abort_cnt != NW_ONES)) begin
        abort_cnt <= abort_cnt + NW'(1);
      end
      if (tmo_hit) begin
        err <= 1'b1;
      end
    end
  end

`ifdef GATE_DELAY_METER_MINMAX_EN
  logic [CW-1:0] min_reg;
  logic [CW-1:0] max_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      min_reg <= CW_ONES;
      max_reg <= '0;
    end else if (done) begin
      if (done_delay < min_reg) begin
        min_reg <= done_delay;
      end
      if (done_delay > max_reg) begin
        max_reg <= done_delay;
      end
    end
  end

  assign min_delay = min_reg;
  assign max_delay = max_reg;
`else
  assign min_delay = CW_ONES;
  assign max_delay = '0;
`endif

endmodule

// File: tb/tb_gate_delay_meter.sv
// Directed bench for gate_delay_meter: rise/fall delays, glitch abort, timeout, clr and mid-wait reset.
module tb_gate_delay_meter;

  logic        clk;
  logic        rst;
  logic        a;
  logic        b;
  logic        c;
  logic        gate_out;
  logic        clr;
  logic        meas_valid;
  logic [7:0]  meas_delay;
  logic        meas_rise;
  logic [7:0]  min_delay;
  logic [7:0]  max_delay;
  logic [15:0] meas_cnt;
  logic [15:0] abort_cnt;
  logic        timeout;
  logic        err;

  int tests_run;
  int tests_failed;

  gate_delay_meter #(.CW(8), .MAX_WAIT(32), .NW(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .gate_out(gate_out), .clr(clr),
    .meas_valid(meas_valid), .meas_delay(meas_delay), .meas_rise(meas_rise),
    .min_delay(min_delay), .max_delay(max_delay), .meas_cnt(meas_cnt),
    .abort_cnt(abort_cnt), .timeout(timeout), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end else begin
      $display("[TB] ok   %s: %0d", tag, actual);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Min/max expectations depend on whether the tracker is built.
  task automatic check_minmax(input string tag, input int mn, input int mx);
`ifdef GATE_DELAY_METER_MINMAX_EN
    check({tag, "_min"}, int'(min_delay), mn);
    check({tag, "_max"}, int'(max_delay), mx);
`else
    check({tag, "_min"}, int'(min_delay), 255);
    check({tag, "_max"}, int'(max_delay), 0);
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, int'(meas_valid), 0);
    check({tag, "_delay"}, int'(meas_delay), 0);
    check({tag, "_rise"}, int'(meas_rise), 0);
    check({tag, "_min"}, int'(min_delay), 255);
    check({tag, "_max"}, int'(max_delay), 0);
    check({tag, "_cnt"}, int'(meas_cnt), 0);
    check({tag, "_abort"}, int'(abort_cnt), 0);
    check({tag, "_tmo"}, int'(timeout), 0);
    check({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1; clr = 1'b0;
    a = 1'b0; b = 1'b0; c = 1'b0; gate_out = 1'b0;

    // Reset held two edges
    tick(); tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();
    check("prime_valid", int'(meas_valid), 0);

    // Rise: exp changes at edge k, gate_out follows at k+3
    a = 1'b1; b = 1'b1;
    tick();
    check("rise_k0_valid", int'(meas_valid), 0);
    tick();
    check("rise_k1_valid", int'(meas_valid), 0);
    tick();
    check("rise_k2_valid", int'(meas_valid), 0);
    gate_out = 1'b1;
    tick();
    check("rise_valid", int'(meas_valid), 1);
    check("rise_delay", int'(meas_delay), 3);
    check("rise_dir", int'(meas_rise), 1);
    check("rise_cnt", int'(meas_cnt), 1);
    check_minmax("rise", 3, 3);
    tick();
    check("rise_pulse_end", int'(meas_valid), 0);

    // Fall: a drops at edge j, gate_out follows at j+5
    a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("fall_j%0d_valid", i), int'(meas_valid), 0);
    end
    gate_out = 1'b0;
    tick();
    check("fall_valid", int'(meas_valid), 1);
    check("fall_delay", int'(meas_delay), 5);
    check("fall_dir", int'(meas_rise), 0);
    check("fall_cnt", int'(meas_cnt), 2);
    check_minmax("fall", 3, 5);

    // Glitch on c for two cycles, gate_out never moves
    c = 1'b1;
    tick();
    check("glitch_e0_valid", int'(meas_valid), 0);
    tick();
    check("glitch_e1_valid", int'(meas_valid), 0);
    c = 1'b0;
    tick();
    check("glitch_e2_valid", int'(meas_valid), 0);
    check("glitch_abort", int'(abort_cnt), 1);
    check("glitch_cnt", int'(meas_cnt), 2);

    // Back in IDLE: same-edge follow gives a zero delay
    c = 1'b1; gate_out = 1'b1;
    tick();
    check("zero_rise_valid", int'(meas_valid), 1);
    check("zero_rise_delay", int'(meas_delay), 0);
    check("zero_rise_dir", int'(meas_rise), 1);
    check("zero_rise_cnt", int'(meas_cnt), 3);
    check_minmax("zero_rise", 0, 5);
    c = 1'b0; gate_out = 1'b0;
    tick();
    check("zero_fall_valid", int'(meas_valid), 1);
    check("zero_fall_dir", int'(meas_rise), 0);
    check("zero_fall_cnt", int'(meas_cnt), 4);

    // Timeout: gate_out stuck at 0 after c rises at edge k
    c = 1'b1;
    tick();
    for (int i = 1; i < 32; i++) begin
      tick();
      if (timeout != 1'b0 || meas_valid != 1'b0) begin
        check($sformatf("tmo_early_k%0d", i), int'({timeout, meas_valid}), 0);
      end
    end
    check("tmo_k31_err", int'(err), 0);
    tick();
    check("tmo_pulse", int'(timeout), 1);
    check("tmo_err", int'(err), 1);
    check("tmo_valid", int'(meas_valid), 0);
    tick();
    check("tmo_pulse_end", int'(timeout), 0);
    check("tmo_err_sticky", int'(err), 1);
    gate_out = 1'b1;
    tick();
    check("tmo_late_valid", int'(meas_valid), 0);
    check("tmo_late_cnt", int'(meas_cnt), 4);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_err", int'(err), 0);
    check("clr_cnt", int'(meas_cnt), 0);
    check("clr_abort", int'(abort_cnt), 0);
    check("clr_min", int'(min_delay), 255);
    check("clr_max", int'(max_delay), 0);

    // Reset mid-WAIT discards a pending rise
    c = 1'b0; gate_out = 1'b0;
    tick();
    check("pre_rst_valid", int'(meas_valid), 1);
    check("pre_rst_cnt", int'(meas_cnt), 1);
    c = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("midrst");
    gate_out = 1'b1;
    tick();
    check("midrst_prime_valid", int'(meas_valid), 0);
    tick();
    check("midrst_idle_valid", int'(meas_valid), 0);
    check("midrst_idle_cnt", int'(meas_cnt), 0);
    c = 1'b0; gate_out = 1'b0;
    tick();
    check("midrst_resume_valid", int'(meas_valid), 1);
    check("midrst_resume_cnt", int'(meas_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gate_delay_meter.md
Name: gate_delay_meter

Overview:
- Downstream consumer of the gate-level delay stage, the and/or network out = (a&b)|c.
- Samples the stage's stimulus (a, b, c) and its observed output on a single clock.
- Computes the expected zero-delay value, then measures how many clock cycles the observed output lags each expected transition.
- Reports per-transition delay plus min/max/count statistics, and flags timeouts and cancelled (inertially swallowed) transitions.

Parameters:
- CW, 8: width of delay counter and delay outputs.
- MAX_WAIT, 32: cycles allowed for the output to follow before timeout; legal range 1..2^CW-1.
- NW, 16: width of the measurement and abort counters.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous active-high reset.
- a, input, 1: stimulus a of the gate stage.
- b, input, 1: stimulus b of the gate stage.
- c, input, 1: stimulus c of the gate stage.
- gate_out, input, 1: observed output of the gate stage.
- clr, input, 1: synchronous clear of statistics and err; does not affect the FSM.
- meas_valid, output, 1: one-cycle pulse when a measurement completes.
- meas_delay, output, CW: delay in cycles of the last completed measurement.
- meas_rise, output, 1: 1 if the last measured transition was 0->1.
- min_delay, output, CW: smallest measured delay.
- max_delay, output, CW: largest measured delay.
- meas_cnt, output, NW: completed measurements; saturates at all-ones.
- abort_cnt, output, NW: cancelled/restarted transitions; saturates.
- timeout, output, 1: one-cycle pulse on timeout.
- err, output, 1: sticky; set on timeout, cleared by rst or clr.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and rst. All outputs are registered.
- exp = (a&b)|c is evaluated from the inputs sampled at each edge. exp_q holds the previous exp. chg = (exp != exp_q) when not in PRIME.
- Reset values:
  - meas_valid, meas_delay, meas_rise, max_delay, meas_cnt, abort_cnt, timeout, err all 0.
  - min_delay = all ones.
  - State = PRIME; cnt = 0.
- States: PRIME, IDLE, WAIT, TMO.
- PRIME: first edge after reset loads exp_q, no event, then go to IDLE.
- IDLE:
  - On chg: if gate_out == exp at the same edge, complete with delay 0 and stay in IDLE.
  - Otherwise go to WAIT with cnt = 1.
- WAIT, evaluated in this priority order:
  - chg again: abort_cnt++. If gate_out == exp, go to IDLE with no measurement (cancelled). Otherwise restart with cnt = 1 and stay in WAIT.
  - gate_out == exp: complete with delay = cnt, go to IDLE.
  - cnt == MAX_WAIT: pulse timeout, set err, go to TMO.
  - Otherwise cnt++.
- TMO:
  - gate_out == exp: go to IDLE with no measurement.
  - chg: abort_cnt++, then apply the IDLE chg rule.
- Complete:
  - meas_valid = 1 for one cycle; meas_delay = delay; meas_rise = exp.
  - meas_cnt++ (saturating).
  - min_delay = min(min_delay, delay); max_delay = max(max_delay, delay).
- Delay definition: the number of edges from the edge at which the expected change is sampled to the edge at which the matching gate_out is sampled. Same edge = 0.
- clr:
  - Sets min_delay to all ones; max_delay, meas_cnt, abort_cnt and err to 0.
  - Takes priority over a same-cycle update of those registers.
  - meas_valid, meas_delay and meas_rise still update normally.
- rst mid-WAIT or TMO: the pending transition is discarded with no measurement; all outputs return to reset values.
- Counters never wrap; cnt never exceeds MAX_WAIT.

Optional Feature:
- Macro: GATE_DELAY_METER_MINMAX_EN.
- When defined: min_delay and max_delay track as specified.
- When undefined: the min/max registers are not built, and the ports are driven constant (min_delay = all ones, max_delay = 0).
- All other behaviour is identical in both builds.

Test Plan:
- Reset: hold rst 2 cycles with a=b=c=0 and gate_out=0 -> all outputs 0, min_delay=255, no meas_valid in PRIME.
- Rise: a=b=1 at edge k, gate_out rises sampled at edge k+3 -> meas_valid pulse, meas_delay=3, meas_rise=1, min=max=3, meas_cnt=1.
- Fall: c=0, then a=0 at edge j, gate_out falls at edge j+5 -> meas_delay=5, meas_rise=0, min=3, max=5, meas_cnt=2. Without the macro: min=255, max=0.
- Glitch: c pulses 1 for 2 cycles while gate_out stays 0 -> no meas_valid, abort_cnt=1, state returns to IDLE.
- Timeout: MAX_WAIT=32, c=1, gate_out held 0 -> timeout pulse at edge k+32, err=1. Later gate_out=1 -> no meas_valid. Then clr=1 -> err=0, meas_cnt=0, min=255.
- Reset mid-WAIT: rst at edge k+2 of a pending rise -> no meas_valid, outputs at reset values, PRIME on the next edge.
